rvx_wb_bridge: RTL

Parametrised bridge between the RVX core's split read/write request/response IO interface and a pipelined Wishbone master port, replacing the hand-wired `cyc`/`stb`/`we` glue in the processor top. It registers one transaction at a time, honours slave stall, and optionally registers the response path. A watchdog terminates transactions the slave never acknowledges and returns a bus error. It sits between the `rvx_core` instance and the Controller (FPGA) or testbench (SIMULATION) bus.

---
 rtl/rvx_wb_bridge_pkg.sv | 18 +
 rtl/rvx_wb_bridge_if.sv | 27 ++
 rtl/rvx_bridge_timer.sv | 32 +++
 rtl/rvx_wb_bridge.sv | 109 ++++++++++
 4 files changed

// File: rtl/rvx_wb_bridge_pkg.sv
// Shared types and constants for the RVX core to pipelined Wishbone bridge.
package rvx_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } state_t;

   // Read data returned alongside bus_error when the slave never acknowledged.
   localparam bit ERR_RDATA_FILL = 1'b0;

   function automatic int cnt_width(input int unsigned timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/rvx_wb_bridge_if.sv
// Pipelined Wishbone master/slave signal bundle driven by the bridge.
interface rvx_wb_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int SEL_W = DATA_WIDTH / 8;

   logic                  core_cyc;
   logic                  core_stb;
   logic                  core_we;
   logic [SEL_W-1:0]      core_sel;
   logic [ADDR_WIDTH-1:0] core_addr;
   logic [DATA_WIDTH-1:0] core_data_out;
   logic [DATA_WIDTH-1:0] core_data_in;
   logic                  core_ack;
   logic                  core_stall;

   modport master (
      output core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out,
      input  core_data_in, core_ack, core_stall
   );

   modport slave (
      input  core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out,
      output core_data_in, core_ack, core_stall
   );
endinterface

// File: rtl/rvx_bridge_timer.sv
// Watchdog counting REQ/WAIT cycles; expired flags the last cycle an ack may land.
module rvx_bridge_timer
   import rvx_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_core,
   input  logic rst_core,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
   end else begin : g_on
      localparam int CW = cnt_width(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count;

      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value regardless of block ordering.
      always_ff @(posedge clk_core) begin
         if (rst_core || clear) count <= '0;
         else if (enable)       count <= count + CW'(1);
      end

      assign expired = enable && (count == LAST);
   end

endmodule

// File: rtl/rvx_wb_bridge.sv
// One-outstanding-transaction bridge from the RVX split request/response bus to pipelined Wishbone.
module rvx_wb_bridge
   import rvx_bridge_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_RESPONSE   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   localparam int unsigned SEL_W         = DATA_WIDTH / 8
) (
   input  logic                  clk_core,
   input  logic                  rst_core,
   input  logic [ADDR_WIDTH-1:0] rw_address,
   input  logic                  read_request,
   input  logic                  write_request,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [SEL_W-1:0]      write_strobe,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_response,
   output logic                  write_response,
   output logic                  bus_error,
   rvx_wb_bridge_if.master       wb
);

   state_t                state, state_nx;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  active;
   logic                  ack_now;
   logic                  expired;

   assign active  = (state == ST_REQ) || (state == ST_WAIT);
   assign ack_now = active && wb.core_ack;

   assign wb.core_cyc = active;
   assign wb.core_stb = (state == ST_REQ);

   rvx_bridge_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk_core(clk_core),
      .rst_core(rst_core),
      .clear   (!active),
      .enable  (active),
      .expired (expired)
   );

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nx       = state;
      read_response  = 1'b0;
      write_response = 1'b0;
      bus_error      = 1'b0;
      read_data      = rdata_q;

      unique case (state)
         ST_IDLE: if (read_request || write_request) state_nx = ST_REQ;
         ST_REQ, ST_WAIT: begin
            // Ack beats both a simultaneous stall and a simultaneous timeout.
            if (wb.core_ack)                            state_nx = (REG_RESPONSE != 0) ? ST_RESP : ST_IDLE;
            else if (expired)                           state_nx = ST_RESP;
            else if (state == ST_REQ && !wb.core_stall) state_nx = ST_WAIT;
         end
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase

      if (state == ST_RESP) begin
         read_response  = !wb.core_we;
         write_response = wb.core_we;
         bus_error      = err_q;
      end else if (REG_RESPONSE == 0 && ack_now) begin
         read_response  = !wb.core_we;
         write_response = wb.core_we;
         if (!wb.core_we) read_data = wb.core_data_in;
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state            <= ST_IDLE;
         err_q            <= 1'b0;
         rdata_q          <= '0;
         wb.core_we       <= 1'b0;
         wb.core_sel      <= '0;
         wb.core_addr     <= '0;
         wb.core_data_out <= '0;
      end else begin
         state <= state_nx;

         if (state == ST_IDLE && (read_request || write_request)) begin
            wb.core_we       <= write_request;
            wb.core_addr     <= rw_address;
            wb.core_data_out <= write_data;
            wb.core_sel      <= write_request ? write_strobe : '1;
         end

         if (active) begin
            if (wb.core_ack) begin
               err_q <= 1'b0;
               if (!wb.core_we) rdata_q <= wb.core_data_in;
            end else if (expired) begin
               err_q <= 1'b1;
               if (!wb.core_we) rdata_q <= {DATA_WIDTH{ERR_RDATA_FILL}};
            end
         end
      end
   end

endmodule
